// File: rtl/word_narrow_pkg.sv
// Shared definitions for the 16->8 word narrowing path: widths, mode codes,
// FSM state encoding and signed saturation bytes.
package word_narrow_pkg;

   localparam int IN_W_DEF  = 16;
   localparam int OUT_W_DEF = 8;

   localparam logic [1:0] MODE_TRUNC = 2'b00;
   localparam logic [1:0] MODE_SAT   = 2'b01;
   localparam logic [1:0] MODE_SPLIT = 2'b10;

   localparam logic [7:0] SAT_MAX = 8'h7F;
   localparam logic [7:0] SAT_MIN = 8'h80;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_LO = 2'd1,
      SEND_HI = 2'd2
   } state_e;

endpackage

// File: rtl/narrow_fit_check.sv
// Decides whether a word survives narrowing to a signed byte, and supplies
// the clamped byte to use when it does not.
module narrow_fit_check
   import word_narrow_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic [IN_W-1:0]  word,
   output logic             fits,
   output logic [OUT_W-1:0] sat_byte
);

   // The upper half must be a pure copy of the byte's sign bit.
   assign fits     = (word[IN_W-1:OUT_W] == {(IN_W-OUT_W){word[OUT_W-1]}});
   assign sat_byte = word[IN_W-1] ? SAT_MIN : SAT_MAX;

endmodule

// File: rtl/word_narrow_unit.sv
// Narrows one 16-bit word per handshake into one or two output bytes, with
// overflow flagging and a saturating overflow counter.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | ready for a word, no byte on the output
//   SEND_LO | first (or only) byte presented, waiting for out_ready
//   SEND_HI | split mode high byte presented, waiting for out_ready
module word_narrow_unit
   import word_narrow_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic             out_ovf,
   input  logic             clr_count,
   output logic [7:0]       ovf_count
);

   state_e           state;
   logic             split_q;
   logic [OUT_W-1:0] hi_byte;
   logic             fits;
   logic [OUT_W-1:0] sat_byte;
   logic             byte_taken;

   narrow_fit_check #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_fit (
      .word     (in_data),
      .fits     (fits),
      .sat_byte (sat_byte)
   );

   assign byte_taken = out_valid && out_ready;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_ovf   <= 1'b0;
         split_q   <= 1'b0;
         hi_byte   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state     <= SEND_LO;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
                  hi_byte   <= in_data[IN_W-1:OUT_W];
                  case (in_mode)
                     MODE_SAT: begin
                        out_data <= fits ? in_data[OUT_W-1:0] : sat_byte;
                        out_ovf  <= !fits;
                        out_last <= 1'b1;
                        split_q  <= 1'b0;
                     end
                     MODE_SPLIT: begin
                        out_data <= in_data[OUT_W-1:0];
                        out_ovf  <= 1'b0;
                        out_last <= 1'b0;
                        split_q  <= 1'b1;
                     end
                     // Reserved code narrows exactly like truncate.
                     default: begin
                        out_data <= in_data[OUT_W-1:0];
                        out_ovf  <= !fits;
                        out_last <= 1'b1;
                        split_q  <= 1'b0;
                     end
                  endcase
               end
            end
            SEND_LO: begin
               if (out_ready) begin
                  if (split_q) begin
                     state    <= SEND_HI;
                     out_data <= hi_byte;
                     out_last <= 1'b1;
                     out_ovf  <= 1'b0;
                  end else begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     in_ready  <= 1'b1;
                  end
               end
            end
            SEND_HI: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

   // Clear wins over a same-cycle overflow handshake.
   always_ff @(posedge CLK) begin
      if (RST || clr_count) begin
         ovf_count <= 8'd0;
      end else if (byte_taken && out_ovf && (ovf_count != 8'hFF)) begin
         ovf_count <= ovf_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_word_narrow_unit.sv
// Directed bench for word_narrow_unit: a queue-based model of expected bytes
// checked every cycle, plus hand-computed literal expectations.
module tb_word_narrow_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_ovf;
   logic        clr_count;
   logic [7:0]  ovf_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic       o;
   } exp_t;

   exp_t exp_q[$];
   int   model_cnt = 0;

   always #5 clk = ~clk;

   word_narrow_unit dut (
      .CLK       (clk),
      .RST       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ovf   (out_ovf),
      .clr_count (clr_count),
      .ovf_count (ovf_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected bytes from the word's signed value, independent of bit tricks.
   task automatic push_word(input logic [15:0] w, input logic [1:0] m);
      int   sv;
      exp_t e;
      sv = int'($signed(w));
      if (m == 2'b10) begin
         e.d = w[7:0];  e.l = 1'b0; e.o = 1'b0; exp_q.push_back(e);
         e.d = w[15:8]; e.l = 1'b1; e.o = 1'b0; exp_q.push_back(e);
      end else begin
         e.l = 1'b1;
         e.o = (sv > 127) || (sv < -128);
         if (m == 2'b01 && sv > 127)       e.d = 8'h7F;
         else if (m == 2'b01 && sv < -128) e.d = 8'h80;
         else                              e.d = w[7:0];
         exp_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         model_cnt = 0;
      end else begin
         chk("m_in_ready", in_ready, exp_q.size() == 0);
         chk("m_out_valid", out_valid, exp_q.size() != 0);
         chk("m_ovf_count", ovf_count, model_cnt);
         if (out_valid && exp_q.size() != 0) begin
            chk("m_byte", {out_data, out_last, out_ovf},
                {exp_q[0].d, exp_q[0].l, exp_q[0].o});
         end
         if (clr_count) begin
            model_cnt = 0;
         end else if (out_valid && out_ready && exp_q.size() != 0 && exp_q[0].o && model_cnt < 255) begin
            model_cnt++;
         end
         if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         if (in_valid && in_ready) push_word(in_data, in_mode);
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [15:0] d, input logic [1:0] m);
      int n;
      in_data  = d;
      in_mode  = m;
      in_valid = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (n == 50) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_mode  = 2'($urandom);
   endtask

   task automatic take(input string name, input logic [7:0] d, input logic l,
                       input logic o, input int stall);
      int n;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      if (n == 50) chk({name, "_timeout"}, 0, 1);
      chk(name, {out_data, out_last, out_ovf}, {d, l, o});
      repeat (stall) begin
         @(negedge clk);
         chk({name, "_stall_ready"}, in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int hs;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0;
      out_ready = 1'b0; clr_count = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_state", {in_ready, out_valid, out_data, out_last, out_ovf, ovf_count},
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
      @(posedge clk); #1;

      send(16'hFF85, 2'b00);
      take("trunc_ff85", 8'h85, 1'b1, 1'b0, 0);
      chk("sext_roundtrip", {{8{out_data[7]}}, out_data}, 16'hFF85);
      send(16'h0123, 2'b00);
      take("trunc_0123", 8'h23, 1'b1, 1'b1, 0);
      @(negedge clk);
      chk("count_one", ovf_count, 8'd1);
      @(posedge clk); #1;
      send(16'h0123, 2'b01);
      take("sat_0123", 8'h7F, 1'b1, 1'b1, 0);
      send(16'hFE00, 2'b01);
      take("sat_fe00", 8'h80, 1'b1, 1'b1, 0);
      send(16'h007F, 2'b01);
      take("sat_007f", 8'h7F, 1'b1, 1'b0, 0);
      send(16'h0123, 2'b11);
      take("rsvd_0123", 8'h23, 1'b1, 1'b1, 0);
      send(16'hABCD, 2'b10);
      take("split_lo", 8'hCD, 1'b0, 1'b0, 3);
      take("split_hi", 8'hAB, 1'b1, 1'b0, 3);
      @(negedge clk);
      chk("split_done_ready", in_ready, 1);
      chk("count_four", ovf_count, 8'd4);
      @(posedge clk); #1;

      // Back-to-back saturate with in_valid held; data changes while busy.
      out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'b01; hs = 0;
      for (int i = 0; i < 8; i++) begin
         in_data = (i % 2 == 0) ? 16'h8001 : 16'h0042 + 16'(i);
         @(negedge clk);
         if (out_valid && out_ready) hs++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("throughput_bytes", hs, 4);
      @(posedge clk); #1;

      // 300 overflowing truncate bytes saturate the counter.
      in_valid = 1'b1; in_mode = 2'b00; in_data = 16'h0123;
      repeat (600) @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("count_sat", ovf_count, 8'd255);
      @(posedge clk); #1;
      out_ready = 1'b0;

      send(16'h0123, 2'b00);
      out_ready = 1'b1; clr_count = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; clr_count = 1'b0;
      @(negedge clk);
      chk("clr_priority", ovf_count, 8'd0);
      @(posedge clk); #1;
      send(16'h7F00, 2'b00);
      take("after_clr", 8'h00, 1'b1, 1'b1, 0);
      @(negedge clk);
      chk("count_after_clr", ovf_count, 8'd1);
      @(posedge clk); #1;

      // Reset while the high byte of a split word is pending.
      send(16'h1234, 2'b10);
      take("rst_split_lo", 8'h34, 1'b0, 1'b0, 0);
      @(negedge clk);
      chk("rst_pre_hi", {out_valid, out_data, out_last}, {1'b1, 8'h12, 1'b1});
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid", {in_ready, out_valid, ovf_count}, {1'b1, 1'b0, 8'h00});
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_hi", out_valid, 0);
      end
      out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
